elastic_register_pipeline: RTL
==============================

// Module: elastic_register_pipeline
// PURPOSE
//   SIZE-stage register pipeline with valid/ready flow control on both ends.
//   Carries words from a producer to a consumer that can stall (out_ready low).
//   Empty stages collapse under stall (bubble squeeze), so no accepted word is
//   ever dropped or duplicated. It is the back-pressured counterpart of the
//   free-running delay pipeline and sits at block boundaries where the sink can stall.
// PARAMETERS
//   WIDTH  16  data word width in bits
//   SIZE   8   number of register stages; >=2; also the maximum occupancy
// PORTS
//   clk        input   1                   rising-edge clock
//   rst_n      input   1                   asynchronous active-low reset
//   in_valid   input   1                   producer presents in_data
//   in_ready   output  1                   pipeline accepts in_data this cycle
//   in_data    input   WIDTH               producer word
//   out_valid  output  1                   out_data holds a valid word
//   out_ready  input   1                   consumer takes out_data this cycle
//   out_data   output  WIDTH               word at the last stage
//   count      output  $clog2(SIZE+1)      number of valid stages (occupancy)
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous and active-low on rst_n.
// - State per stage k (0..SIZE-1): data_k[WIDTH-1:0] and v_k. Stage SIZE-1 drives the outputs.
// - Reset: all v_k=0, data_k=0, count=0, out_valid=0, out_data=0.
//   in_ready=0 while rst_n is low. in_ready=1 in the first cycle after release.
// - Transfers:
//   * Input transfer  = in_valid & in_ready.
//   * Output transfer = out_valid & out_ready.
// - Advance rule, evaluated combinationally from the last stage back:
//   * adv_{SIZE-1} = ~v_{SIZE-1} | out_ready
//   * adv_k = ~v_k | adv_{k+1}
//   * Stage k+1 loads data_k and v_k when adv_{k+1}.
//   * Stage 0 loads in_data and in_valid when adv_0.
//   * A stage that does not advance holds its contents.
// - in_ready = adv_0. A word may enter while the pipe is full if out_ready is
//   high in the same cycle (simultaneous accept and retire).
// - Latency: with no stall, a word accepted at edge N is at the output
//   (out_valid=1) after edge N+SIZE-1. This equals the free-running pipeline depth.
// - Throughput: 1 word per cycle when out_ready is held high.
// - Hold: while out_valid=1 and out_ready=0, out_data and out_valid are stable.
// - in_ready may depend combinationally on out_ready (ripple path). There is
//   no combinational path from in_valid or in_data to any output.
// - count: +1 on input transfer only, -1 on output transfer only, unchanged
//   when both or neither occur. count == number of set v_k at all times.
//   Range 0..SIZE; it never wraps.
// - Full (count==SIZE) with out_ready=0: in_ready=0 and in_valid is ignored.
// - Empty (count==0): out_valid=0. out_data keeps the last value and is don't-care.
// - Words exit in acceptance order with bit-exact data.
// - Reset asserted mid-stream: all contents are discarded immediately and no
//   output transfer is reported. The pipe restarts empty after release.
// - in_valid is not required to stay high once asserted. A word not accepted
//   may be withdrawn.
// TESTING
// 1. Reset, out_ready=1, stream 0x0001..0x0010 back-to-back ->
//    - first out_valid 7 cycles after the first accept;
//    - 16 words in order, 1 per cycle;
//    - count peaks at 8.
// 2. out_ready=0, push 0xA000..0xA009 ->
//    - accepts exactly 8; in_ready=0 after the 8th;
//    - count=8; out_data=0xA000 held stable.
//    Then raise out_ready -> remaining 0xA008,0xA009 enter and all 10 exit in order.
// 3. Full pipe, in_valid=1 and out_ready=1 in the same cycle ->
//    - both transfers occur; count stays 8;
//    - the word accepted next cycle sits behind the 7 already held.
// 4. Sparse input (valid every 3rd cycle, 0x1111,0x2222,0x3333) with out_ready
//    low for 10 cycles then high ->
//    - bubbles collapse; all 3 words sit adjacent at the tail;
//    - they exit on 3 consecutive cycles.
// 5. Random in_valid/out_ready (50%), 2000 words ->
//    - scoreboard shows no loss, no duplication, order preserved;
//    - count always equals the model occupancy.
// 6. Pipe holding 5 words, drop rst_n low asynchronously mid-cycle ->
//    - out_valid=0 and count=0 immediately;
//    - after release, in_ready=1 and a new word 0xBEEF emerges alone after 7 cycles.

Source files
------------

// File: rtl/elastic_register_pipeline.sv
// SIZE-stage valid/ready register pipeline. Empty stages collapse under a
// downstream stall, so accepted words are never dropped or duplicated.
module elastic_register_pipeline #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(SIZE+1)-1:0] count
);

   localparam int CW = $clog2(SIZE+1);

   logic [SIZE-1:0][WIDTH-1:0] data_reg;
   logic [SIZE-1:0][WIDTH-1:0] data_next;
   logic [SIZE-1:0]            v_reg;
   logic [SIZE-1:0]            v_next;
   logic [SIZE-1:0]            adv;
   logic [CW-1:0]              count_reg;
   logic [CW-1:0]              count_next;
   logic                       in_fire;
   logic                       out_fire;

   // Closed form of the ripple: stage k may advance if the sink takes a word
   // or any stage from k to the tail is empty.
   generate
      for (genvar gi = 0; gi < SIZE; gi++) begin : g_adv
         assign adv[gi] = out_ready | ~(&v_reg[SIZE-1:gi]);
      end
   endgenerate

   // Data only moves with a valid word, so an emptied tail keeps its last value.
   generate
      for (genvar gi = 0; gi < SIZE; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign v_next[gi]    = adv[gi] ? in_valid : v_reg[gi];
            assign data_next[gi] = (adv[gi] && in_valid) ? in_data : data_reg[gi];
         end else begin : g_body
            assign v_next[gi]    = adv[gi] ? v_reg[gi-1] : v_reg[gi];
            assign data_next[gi] = (adv[gi] && v_reg[gi-1]) ? data_reg[gi-1] : data_reg[gi];
         end
      end
   endgenerate

   assign in_ready  = adv[0] & rst_n;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = v_reg[SIZE-1] & out_ready;
   assign out_valid = v_reg[SIZE-1];
   assign out_data  = data_reg[SIZE-1];
   assign count     = count_reg;

   always_comb begin
      count_next = count_reg;
      case ({in_fire, out_fire})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg  <= '0;
         v_reg     <= '0;
         count_reg <= '0;
      end else begin
         data_reg  <= data_next;
         v_reg     <= v_next;
         count_reg <= count_next;
      end
   end

endmodule
